// File: rtl/axi_router_pkg.sv
// Shared constants and slicing helpers for the AXI write-address router.
// Holds the default six-region address map used by axi_aw_router.
package axi_router_pkg;

    localparam int DEF_NO_S   = 6;
    localparam int DEF_ADDR_W = 32;

    // Slave j occupies bits [j*ADDR_W +: ADDR_W]; slave 0 is the rightmost word.
    localparam logic [DEF_NO_S*DEF_ADDR_W-1:0] DEF_REGION_START = {
        32'h0010_9000, 32'h0010_7000, 32'h0000_7000,
        32'h0000_3000, 32'h0000_1000, 32'h0000_0000
    };

    localparam logic [DEF_NO_S*DEF_ADDR_W-1:0] DEF_REGION_END = {
        32'h0010_AFFF, 32'h0010_8FFF, 32'h0010_6FFF,
        32'h0000_6FFF, 32'h0000_2FFF, 32'h0000_0FFF
    };

    // Low bit of field idx in a packed vector of w-bit fields.
    function automatic int fld_lo(input int idx, input int w);
        return idx * w;
    endfunction

endpackage

// File: rtl/axi_rr_arbiter.sv
// Round-robin arbiter: picks the first requester at or after its pointer and
// moves the pointer just past the winner whenever a grant is taken.
module axi_rr_arbiter #(
    parameter int NO_M  = 4,
    parameter int IDX_W = $clog2(NO_M)
) (
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic             i_en,
    input  logic [NO_M-1:0]  i_req,
    output logic [NO_M-1:0]  o_gnt,
    output logic [IDX_W-1:0] o_idx,
    output logic             o_vld
);

    logic [IDX_W-1:0] r_ptr;

    // Scan from the farthest offset down so the nearest requester wins last.
    always_comb begin
        int m;
        o_vld = 1'b0;
        o_idx = '0;
        m     = 0;
        for (int k = NO_M - 1; k >= 0; k--) begin
            m = (int'(r_ptr) + k) % NO_M;
            if (i_req[IDX_W'(m)]) begin
                o_vld = 1'b1;
                o_idx = IDX_W'(m);
            end
        end
    end

    assign o_gnt = (i_en && o_vld) ? (NO_M'(1) << o_idx) : '0;

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_ptr <= '0;
        end else if (i_en && o_vld) begin
            r_ptr <= (o_idx == IDX_W'(NO_M - 1)) ? '0 : o_idx + 1'b1;
        end
    end

endmodule

// File: rtl/axi_aw_router.sv
// AW-channel router: decodes masters onto NO_S regions plus an error port,
// arbitrates round-robin per port and tracks write ownership per port.
module axi_aw_router
    import axi_router_pkg::*;
#(
    parameter int NO_M     = 4,
    parameter int NO_S     = 6,
    parameter int ADDR_W   = 32,
    parameter int M_ID_W   = 9,
    parameter int MIDX_W   = $clog2(NO_M),
    parameter logic [NO_S*ADDR_W-1:0] REGION_START = DEF_REGION_START,
    parameter logic [NO_S*ADDR_W-1:0] REGION_END   = DEF_REGION_END,
    parameter int WQ_DEPTH = 4
) (
    input  logic                              aclk,
    input  logic                              areset,
    input  logic [NO_M-1:0]                   m_awvalid,
    output logic [NO_M-1:0]                   m_awready,
    input  logic [NO_M*ADDR_W-1:0]            m_awaddr,
    input  logic [NO_M*M_ID_W-1:0]            m_awid,
    input  logic [NO_M*8-1:0]                 m_awlen,
    output logic [NO_S:0]                     s_awvalid,
    input  logic [NO_S:0]                     s_awready,
    output logic [(NO_S+1)*ADDR_W-1:0]        s_awaddr,
    output logic [(NO_S+1)*(M_ID_W+MIDX_W)-1:0] s_awid,
    output logic [(NO_S+1)*8-1:0]             s_awlen,
    input  logic [NO_S:0]                     s_wlast_hs,
    output logic [(NO_S+1)*MIDX_W-1:0]        wsel,
    output logic [NO_S:0]                     wsel_valid,
    output logic                              wq_err
);

    localparam int NP    = NO_S + 1;
    localparam int TGT_W = $clog2(NP);
    localparam int SID_W = M_ID_W + MIDX_W;
    localparam int PTR_W = $clog2(WQ_DEPTH);

    // Error port subtracts nothing, so its base is an appended zero word.
    localparam logic [NP*ADDR_W-1:0] BASE = {{ADDR_W{1'b0}}, REGION_START};

    logic [NO_M-1:0][ADDR_W-1:0] w_maddr;
    logic [NO_M-1:0][M_ID_W-1:0] w_mid;
    logic [NO_M-1:0][7:0]        w_mlen;
    logic [NO_M-1:0][TGT_W-1:0]  w_tgt;

    logic [NP-1:0][NO_M-1:0]   w_req;
    logic [NP-1:0][NO_M-1:0]   w_gnt;
    logic [NP-1:0][MIDX_W-1:0] w_win;
    logic [NP-1:0]             w_win_vld;
    logic [NP-1:0]             w_load_ok;
    logic [NP-1:0]             w_full;
    logic [NP-1:0]             w_empty;
    logic [NP-1:0]             w_push;
    logic [NP-1:0]             w_pop;
    logic [NP-1:0][MIDX_W-1:0] w_wsel;

    logic [NP-1:0]                             r_vld;
    logic [NP-1:0][ADDR_W-1:0]                 r_addr;
    logic [NP-1:0][SID_W-1:0]                  r_id;
    logic [NP-1:0][7:0]                        r_len;
    logic [NP-1:0][WQ_DEPTH-1:0][MIDX_W-1:0]   r_wq;
    logic [NP-1:0][PTR_W-1:0]                  r_wp;
    logic [NP-1:0][PTR_W-1:0]                  r_rp;
    logic [NP-1:0][PTR_W:0]                    r_cnt;
    logic                                      r_wq_err;

    assign w_maddr = m_awaddr;
    assign w_mid   = m_awid;
    assign w_mlen  = m_awlen;

    // Lowest matching region wins, so scan downward and let later hits override.
    always_comb begin
        for (int i = 0; i < NO_M; i++) begin
            w_tgt[i] = TGT_W'(NO_S);
            for (int j = NO_S - 1; j >= 0; j--) begin
                if (w_maddr[i] >= REGION_START[fld_lo(j, ADDR_W) +: ADDR_W] &&
                    w_maddr[i] <= REGION_END[fld_lo(j, ADDR_W) +: ADDR_W]) begin
                    w_tgt[i] = TGT_W'(j);
                end
            end
        end
    end

    always_comb begin
        for (int j = 0; j < NP; j++) begin
            for (int i = 0; i < NO_M; i++) begin
                w_req[j][i] = m_awvalid[i] && (w_tgt[i] == TGT_W'(j));
            end
            w_full[j]    = (r_cnt[j] == (PTR_W+1)'(WQ_DEPTH));
            w_empty[j]   = (r_cnt[j] == '0);
            w_load_ok[j] = !areset && (!r_vld[j] || s_awready[j]) &&
                           (!w_full[j] || s_wlast_hs[j]);
            w_push[j]    = w_load_ok[j] && w_win_vld[j];
            w_pop[j]     = s_wlast_hs[j] && !w_empty[j];
            w_wsel[j]    = r_wq[j][r_rp[j]];
        end
    end

    for (genvar j = 0; j < NP; j++) begin : g_arb
        axi_rr_arbiter #(
            .NO_M  (NO_M),
            .IDX_W (MIDX_W)
        ) u_arb (
            .i_clk (aclk),
            .i_rst (areset),
            .i_en  (w_load_ok[j]),
            .i_req (w_req[j]),
            .o_gnt (w_gnt[j]),
            .o_idx (w_win[j]),
            .o_vld (w_win_vld[j])
        );
    end

    // A master decodes to exactly one port, so OR-ing per-port grants is safe.
    always_comb begin
        m_awready = '0;
        for (int j = 0; j < NP; j++) begin
            m_awready = m_awready | w_gnt[j];
        end
    end

    always_ff @(posedge aclk) begin
        if (areset) begin
            r_vld    <= '0;
            r_addr   <= '0;
            r_id     <= '0;
            r_len    <= '0;
            r_wq     <= '0;
            r_wp     <= '0;
            r_rp     <= '0;
            r_cnt    <= '0;
            r_wq_err <= 1'b0;
        end else begin
            for (int j = 0; j < NP; j++) begin
                if (w_push[j]) begin
                    r_vld[j]          <= 1'b1;
                    r_addr[j]         <= w_maddr[w_win[j]] - BASE[fld_lo(j, ADDR_W) +: ADDR_W];
                    r_id[j]           <= {w_win[j], w_mid[w_win[j]]};
                    r_len[j]          <= w_mlen[w_win[j]];
                    r_wq[j][r_wp[j]]  <= w_win[j];
                    r_wp[j]           <= r_wp[j] + 1'b1;
                end else if (s_awready[j]) begin
                    r_vld[j] <= 1'b0;
                end
                if (w_pop[j]) begin
                    r_rp[j] <= r_rp[j] + 1'b1;
                end
                // Push and pop together on a full queue leaves the count at depth.
                case ({w_push[j], w_pop[j]})
                    2'b10:   r_cnt[j] <= r_cnt[j] + 1'b1;
                    2'b01:   r_cnt[j] <= r_cnt[j] - 1'b1;
                    default: r_cnt[j] <= r_cnt[j];
                endcase
            end
            if (|(s_wlast_hs & w_empty)) begin
                r_wq_err <= 1'b1;
            end
        end
    end

    assign s_awvalid  = r_vld;
    assign s_awaddr   = r_addr;
    assign s_awid     = r_id;
    assign s_awlen    = r_len;
    assign wsel       = w_wsel;
    assign wsel_valid = ~w_empty;
    assign wq_err     = r_wq_err;

endmodule

// File: tb/tb_axi_aw_router.sv
// Bench for axi_aw_router: directed scenarios plus a randomized run, all checked
// against a queue-based reference model of the routing and ordering rules.
module tb_axi_aw_router;

    localparam int NO_M = 4;
    localparam int NO_S = 6;
    localparam int NP   = NO_S + 1;
    localparam int AW   = 32;
    localparam int IDW  = 9;
    localparam int MW   = 2;
    localparam int SIDW = IDW + MW;
    localparam int WQ   = 4;

    logic                 aclk = 1'b0;
    logic                 areset;
    logic [NO_M-1:0]      m_awvalid, m_awready;
    logic [NO_M*AW-1:0]   m_awaddr;
    logic [NO_M*IDW-1:0]  m_awid;
    logic [NO_M*8-1:0]    m_awlen;
    logic [NP-1:0]        s_awvalid, s_awready, s_wlast_hs, wsel_valid;
    logic [NP*AW-1:0]     s_awaddr;
    logic [NP*SIDW-1:0]   s_awid;
    logic [NP*8-1:0]      s_awlen;
    logic [NP*MW-1:0]     wsel;
    logic                 wq_err;

    axi_aw_router dut (
        .aclk       (aclk),
        .areset     (areset),
        .m_awvalid  (m_awvalid),
        .m_awready  (m_awready),
        .m_awaddr   (m_awaddr),
        .m_awid     (m_awid),
        .m_awlen    (m_awlen),
        .s_awvalid  (s_awvalid),
        .s_awready  (s_awready),
        .s_awaddr   (s_awaddr),
        .s_awid     (s_awid),
        .s_awlen    (s_awlen),
        .s_wlast_hs (s_wlast_hs),
        .wsel       (wsel),
        .wsel_valid (wsel_valid),
        .wq_err     (wq_err)
    );

    always #5 aclk = ~aclk;

    int n_chk  = 0;
    int n_fail = 0;

    logic [AW-1:0] RS [NO_S] = '{32'h0, 32'h1000, 32'h3000, 32'h7000, 32'h107000, 32'h109000};
    logic [AW-1:0] RE [NO_S] = '{32'hFFF, 32'h2FFF, 32'h6FFF, 32'h106FFF, 32'h108FFF, 32'h10AFFF};

    // Reference model: per-port holding register, rr pointer, ownership queue.
    int              rr  [NP];
    bit              mv  [NP];
    logic [AW-1:0]   ma  [NP];
    logic [SIDW-1:0] mi  [NP];
    logic [7:0]      ml  [NP];
    int              q   [NP][$];
    bit              merr;
    logic [NO_M-1:0] exp_rdy;
    int              exp_win [NP];

    function automatic int decode(logic [AW-1:0] a);
        for (int j = 0; j < NO_S; j++) if (a >= RS[j] && a <= RE[j]) return j;
        return NO_S;
    endfunction

    function automatic logic [AW-1:0]   g_maddr(int i); return m_awaddr[i*AW +: AW];   endfunction
    function automatic logic [AW-1:0]   g_addr(int j);  return s_awaddr[j*AW +: AW];   endfunction
    function automatic logic [SIDW-1:0] g_id(int j);    return s_awid[j*SIDW +: SIDW]; endfunction
    function automatic logic [7:0]      g_len(int j);   return s_awlen[j*8 +: 8];      endfunction
    function automatic logic [MW-1:0]   g_wsel(int j);  return wsel[j*MW +: MW];       endfunction

    task automatic model_reset();
        for (int j = 0; j < NP; j++) begin
            rr[j] = 0; mv[j] = 0; ma[j] = '0; mi[j] = '0; ml[j] = '0; q[j].delete();
        end
        merr = 0;
    endtask

    task automatic model_eval();
        bit ok;
        int m;
        exp_rdy = '0;
        for (int j = 0; j < NP; j++) begin
            exp_win[j] = -1;
            ok = !areset && (!mv[j] || s_awready[j]) && (q[j].size() < WQ || s_wlast_hs[j]);
            if (ok) begin
                for (int k = 0; k < NO_M; k++) begin
                    m = (rr[j] + k) % NO_M;
                    if (m_awvalid[m] && decode(g_maddr(m)) == j) begin
                        exp_win[j] = m;
                        exp_rdy[m] = 1'b1;
                        break;
                    end
                end
            end
        end
    endtask

    task automatic model_commit();
        int w;
        if (areset) begin
            model_reset();
            return;
        end
        for (int j = 0; j < NP; j++) begin
            if (s_wlast_hs[j]) begin
                if (q[j].size() > 0) void'(q[j].pop_front());
                else merr = 1;
            end
            if (exp_win[j] >= 0) begin
                w = exp_win[j];
                mv[j] = 1;
                if (j < NO_S) ma[j] = g_maddr(w) - RS[j];
                else          ma[j] = g_maddr(w);
                mi[j] = {MW'(w), m_awid[w*IDW +: IDW]};
                ml[j] = m_awlen[w*8 +: 8];
                rr[j] = (w + 1) % NO_M;
                q[j].push_back(w);
            end else if (s_awready[j]) begin
                mv[j] = 0;
            end
        end
    endtask

    task automatic settle(); model_eval(); #1; endtask
    task automatic clk(); @(posedge aclk); model_commit(); #1; endtask

    task automatic idle_inputs();
        m_awvalid = '0; m_awaddr = '0; m_awid = '0; m_awlen = '0;
        s_awready = '0; s_wlast_hs = '0;
    endtask

    task automatic set_m(int i, logic [AW-1:0] a, logic [IDW-1:0] id, logic [7:0] len);
        m_awvalid[i]          = 1'b1;
        m_awaddr[i*AW +: AW]  = a;
        m_awid[i*IDW +: IDW]  = id;
        m_awlen[i*8 +: 8]     = len;
    endtask

    task automatic do_reset();
        @(negedge aclk);
        idle_inputs();
        areset = 1'b1;
        settle(); clk();
        @(negedge aclk);
        settle(); clk();
        @(negedge aclk);
        areset = 1'b0;
    endtask

    task automatic test_reset();
        @(negedge aclk);
        idle_inputs();
        areset = 1'b1;
        s_awready = '1;
        set_m(0, 32'h1004, 9'h1, 8'd0);
        settle();
        n_chk++; if (m_awready !== 4'b0000) begin n_fail++; $display("FAIL reset_awready: got %b expected 0000", m_awready); end
        clk();
        n_chk++; if (s_awvalid !== '0) begin n_fail++; $display("FAIL reset_awvalid: got %b expected 0", s_awvalid); end
        n_chk++; if (wsel_valid !== '0) begin n_fail++; $display("FAIL reset_wsel_valid: got %b expected 0", wsel_valid); end
        n_chk++; if (wq_err !== 1'b0) begin n_fail++; $display("FAIL reset_wq_err: got %b expected 0", wq_err); end
        n_chk++; if (s_awaddr !== '0 || s_awid !== '0) begin n_fail++; $display("FAIL reset_outregs: got addr %h id %h expected 0", s_awaddr, s_awid); end
        @(negedge aclk);
        idle_inputs();
        areset = 1'b0;
    endtask

    task automatic test_decode_offset();
        do_reset();
        s_awready = '1;
        set_m(0, 32'h1004, 9'h1A5, 8'd7);
        settle();
        n_chk++; if (m_awready !== 4'b0001) begin n_fail++; $display("FAIL dec_awready: got %b expected 0001", m_awready); end
        clk();
        n_chk++; if (s_awvalid !== 7'b0000010) begin n_fail++; $display("FAIL dec_awvalid: got %b expected 0000010", s_awvalid); end
        n_chk++; if (g_addr(1) !== 32'h4) begin n_fail++; $display("FAIL dec_offset: got %h expected 4", g_addr(1)); end
        n_chk++; if (g_id(1) !== {2'd0, 9'h1A5}) begin n_fail++; $display("FAIL dec_id: got %h expected %h", g_id(1), {2'd0, 9'h1A5}); end
        n_chk++; if (g_len(1) !== 8'd7) begin n_fail++; $display("FAIL dec_len: got %0d expected 7", g_len(1)); end
        n_chk++; if (wsel_valid !== 7'b0000010 || g_wsel(1) !== 2'd0) begin n_fail++; $display("FAIL dec_wsel: got v=%b sel=%0d expected v=0000010 sel=0", wsel_valid, g_wsel(1)); end
    endtask

    task automatic test_round_robin();
        logic [3:0] e;
        logic [SIDW-1:0] id;
        do_reset();
        s_awready = '1;
        set_m(0, 32'h3000, 9'd1, 8'd0);
        set_m(1, 32'h3004, 9'd2, 8'd1);
        set_m(2, 32'h6FFC, 9'd3, 8'd2);
        for (int c = 0; c < 6; c++) begin
            s_wlast_hs[2] = (c > 0);
            settle();
            e = 4'(1 << (c % 3));
            n_chk++; if (m_awready !== e) begin n_fail++; $display("FAIL rr_grant_%0d: got %b expected %b", c, m_awready, e); end
            clk();
            id = g_id(2);
            n_chk++; if (s_awvalid[2] !== 1'b1 || id[SIDW-1:IDW] !== MW'(c % 3)) begin n_fail++; $display("FAIL rr_out_%0d: got v=%b m=%0d expected v=1 m=%0d", c, s_awvalid[2], id[SIDW-1:IDW], c % 3); end
            @(negedge aclk);
        end
    endtask

    task automatic test_error_port();
        do_reset();
        s_awready = '1;
        set_m(3, 32'h0020_0000, 9'h055, 8'd3);
        settle();
        n_chk++; if (m_awready !== 4'b1000) begin n_fail++; $display("FAIL err_awready: got %b expected 1000", m_awready); end
        clk();
        n_chk++; if (s_awvalid !== 7'b1000000) begin n_fail++; $display("FAIL err_awvalid: got %b expected 1000000", s_awvalid); end
        n_chk++; if (g_addr(6) !== 32'h0020_0000) begin n_fail++; $display("FAIL err_rawaddr: got %h expected 00200000", g_addr(6)); end
        n_chk++; if (g_id(6) !== {2'd3, 9'h055} || g_wsel(6) !== 2'd3) begin n_fail++; $display("FAIL err_id: got id %h sel %0d expected id %h sel 3", g_id(6), g_wsel(6), {2'd3, 9'h055}); end
    endtask

    task automatic test_backpressure();
        do_reset();
        set_m(1, 32'h107000, 9'd10, 8'd4);
        settle();
        n_chk++; if (m_awready !== 4'b0010) begin n_fail++; $display("FAIL bp_first: got %b expected 0010", m_awready); end
        clk();
        for (int c = 0; c < 3; c++) begin
            @(negedge aclk);
            m_awid[1*IDW +: IDW] = 9'd11;
            m_awaddr[1*AW +: AW] = 32'h107010;
            settle();
            n_chk++; if (m_awready !== 4'b0000) begin n_fail++; $display("FAIL bp_stall_%0d: got %b expected 0000", c, m_awready); end
            clk();
            n_chk++; if (s_awvalid[4] !== 1'b1 || g_id(4) !== {2'd1, 9'd10} || g_addr(4) !== 32'h0) begin n_fail++; $display("FAIL bp_hold_%0d: got v=%b id=%h addr=%h expected v=1 id=%h addr=0", c, s_awvalid[4], g_id(4), g_addr(4), {2'd1, 9'd10}); end
        end
        for (int c = 0; c < 4; c++) begin
            @(negedge aclk);
            s_awready[4]  = 1'b1;
            s_wlast_hs[4] = (c > 0);
            m_awid[1*IDW +: IDW] = 9'(11 + c);
            settle();
            n_chk++; if (m_awready !== 4'b0010) begin n_fail++; $display("FAIL bp_release_%0d: got %b expected 0010", c, m_awready); end
            clk();
            n_chk++; if (g_id(4) !== {2'd1, 9'(11 + c)} || g_addr(4) !== 32'h10) begin n_fail++; $display("FAIL bp_next_%0d: got id=%h addr=%h expected id=%h addr=10", c, g_id(4), g_addr(4), {2'd1, 9'(11 + c)}); end
        end
    endtask

    task automatic test_fifo_full();
        do_reset();
        s_awready[0] = 1'b1;
        set_m(0, 32'h10, 9'd5, 8'd0);
        set_m(1, 32'h20, 9'd6, 8'd0);
        for (int c = 0; c < 4; c++) begin
            settle();
            n_chk++; if (m_awready !== ((c % 2) ? 4'b0010 : 4'b0001)) begin n_fail++; $display("FAIL ff_grant_%0d: got %b expected %b", c, m_awready, (c % 2) ? 4'b0010 : 4'b0001); end
            clk();
            @(negedge aclk);
        end
        settle();
        n_chk++; if (m_awready !== 4'b0000) begin n_fail++; $display("FAIL ff_full_block: got %b expected 0000", m_awready); end
        clk();
        n_chk++; if (wsel_valid[0] !== 1'b1 || g_wsel(0) !== 2'd0) begin n_fail++; $display("FAIL ff_head: got v=%b sel=%0d expected v=1 sel=0", wsel_valid[0], g_wsel(0)); end
        @(negedge aclk);
        s_wlast_hs[0] = 1'b1;
        settle();
        n_chk++; if (m_awready !== 4'b0001) begin n_fail++; $display("FAIL ff_pop_grant: got %b expected 0001", m_awready); end
        clk();
        n_chk++; if (g_wsel(0) !== 2'd1 || g_id(0) !== {2'd0, 9'd5}) begin n_fail++; $display("FAIL ff_advance: got sel=%0d id=%h expected sel=1 id=%h", g_wsel(0), g_id(0), {2'd0, 9'd5}); end
        @(negedge aclk);
        s_wlast_hs[0] = 1'b0;
        settle();
        n_chk++; if (m_awready !== 4'b0000) begin n_fail++; $display("FAIL ff_still_full: got %b expected 0000", m_awready); end
        clk();
    endtask

    task automatic test_wq_err_reset();
        do_reset();
        s_wlast_hs[5] = 1'b1;
        settle(); clk();
        n_chk++; if (wq_err !== 1'b1) begin n_fail++; $display("FAIL wqerr_set: got %b expected 1", wq_err); end
        @(negedge aclk);
        s_wlast_hs = '0;
        set_m(2, 32'h109010, 9'd7, 8'd1);
        set_m(0, 32'h0, 9'd8, 8'd2);
        settle(); clk();
        n_chk++; if (wq_err !== 1'b1) begin n_fail++; $display("FAIL wqerr_sticky: got %b expected 1", wq_err); end
        n_chk++; if (s_awvalid !== 7'b0100001 || wsel_valid !== 7'b0100001) begin n_fail++; $display("FAIL wqerr_burst: got v=%b wv=%b expected 0100001", s_awvalid, wsel_valid); end
        @(negedge aclk);
        areset = 1'b1;
        settle(); clk();
        n_chk++; if (s_awvalid !== '0 || wsel_valid !== '0 || wq_err !== 1'b0) begin n_fail++; $display("FAIL midreset: got v=%b wv=%b err=%b expected all 0", s_awvalid, wsel_valid, wq_err); end
        @(negedge aclk);
        areset = 1'b0;
        idle_inputs();
    endtask

    task automatic test_random();
        int j, r;
        logic [AW-1:0] a;
        do_reset();
        for (int n = 0; n < 400; n++) begin
            for (int i = 0; i < NO_M; i++) begin
                r = $urandom_range(0, 4);
                j = $urandom_range(0, NO_S - 1);
                case (r)
                    0: a = RS[j];
                    1: a = RE[j];
                    2: a = RE[j] + 32'd1;
                    3: a = RS[j] + 32'($urandom_range(0, int'(RE[j] - RS[j])));
                    default: a = 32'h0020_0000 + 32'($urandom_range(0, 32'hFFFF));
                endcase
                m_awvalid[i] = 1'b0;
                if ($urandom_range(0, 99) < 60) set_m(i, a, 9'($urandom), 8'($urandom));
            end
            for (int k = 0; k < NP; k++) begin
                s_awready[k]  = ($urandom_range(0, 99) < 70);
                s_wlast_hs[k] = ($urandom_range(0, 99) < 25);
            end
            areset = ($urandom_range(0, 199) == 0);
            settle();
            n_chk++; if (m_awready !== exp_rdy) begin n_fail++; $display("FAIL rnd_awready_%0d: got %b expected %b", n, m_awready, exp_rdy); end
            clk();
            for (int k = 0; k < NP; k++) begin
                n_chk++; if (s_awvalid[k] !== mv[k]) begin n_fail++; $display("FAIL rnd_valid_%0d_p%0d: got %b expected %b", n, k, s_awvalid[k], mv[k]); end
                if (mv[k]) begin
                    n_chk++; if (g_addr(k) !== ma[k] || g_id(k) !== mi[k] || g_len(k) !== ml[k]) begin n_fail++; $display("FAIL rnd_beat_%0d_p%0d: got %h/%h/%h expected %h/%h/%h", n, k, g_addr(k), g_id(k), g_len(k), ma[k], mi[k], ml[k]); end
                end
                n_chk++; if (wsel_valid[k] !== (q[k].size() > 0)) begin n_fail++; $display("FAIL rnd_wselv_%0d_p%0d: got %b expected %0d", n, k, wsel_valid[k], q[k].size() > 0); end
                if (q[k].size() > 0) begin
                    n_chk++; if (g_wsel(k) !== MW'(q[k][0])) begin n_fail++; $display("FAIL rnd_wsel_%0d_p%0d: got %0d expected %0d", n, k, g_wsel(k), q[k][0]); end
                end
            end
            n_chk++; if (wq_err !== merr) begin n_fail++; $display("FAIL rnd_wqerr_%0d: got %b expected %b", n, wq_err, merr); end
            @(negedge aclk);
        end
        areset = 1'b0;
        idle_inputs();
    endtask

    initial begin
        areset = 1'b1;
        idle_inputs();
        model_reset();
        test_reset();
        test_decode_offset();
        test_round_robin();
        test_error_port();
        test_backpressure();
        test_fifo_full();
        test_wq_err_reset();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/axi_aw_router.md
Name: axi_aw_router

Overview:
- Parametrised write-address router and arbiter for the AXI interconnect. Generalises the fixed 4-master/6-slave address map into parameters.
- Decodes each master's AW request against NO_S address regions and applies round-robin arbitration per slave. Forwards a registered AW beat with the master number appended to the ID.
- Keeps a per-slave write-order FIFO of master indices so the W-channel mux knows which master owns each burst. Unmapped addresses go to an extra error port (index NO_S).

Parameters:
- NO_M, 4, number of masters.
- NO_S, 6, number of mapped slaves; the error port is index NO_S.
- ADDR_W, 32, address width.
- M_ID_W, 9, master ID width.
- MIDX_W, $clog2(NO_M), master-index width; slave ID width is M_ID_W+MIDX_W.
- REGION_START, {NO_S*ADDR_W}, packed start addresses, slave j at bits [j*ADDR_W +: ADDR_W]. Default is the S0..S5 map: 0x0, 0x1000, 0x3000, 0x7000, 0x107000, 0x109000.
- REGION_END, {NO_S*ADDR_W}, inclusive end addresses. Default: 0xFFF, 0x2FFF, 0x6FFF, 0x106FFF, 0x108FFF, 0x10AFFF.
- WQ_DEPTH, 4, write-order FIFO depth per port (power of 2, at least 2).

Ports:
- aclk  in  1  clock.
- areset  in  1  synchronous, active-high reset.
- m_awvalid  in  NO_M  per-master AW valid.
- m_awready  out  NO_M  per-master AW ready.
- m_awaddr  in  NO_M*ADDR_W  packed addresses.
- m_awid  in  NO_M*M_ID_W  packed IDs.
- m_awlen  in  NO_M*8  packed burst lengths.
- s_awvalid  out  NO_S+1  per-port AW valid.
- s_awready  in  NO_S+1  per-port AW ready.
- s_awaddr  out  (NO_S+1)*ADDR_W  region offset (addr - REGION_START); raw address on the error port.
- s_awid  out  (NO_S+1)*(M_ID_W+MIDX_W)  {master index, m_awid}.
- s_awlen  out  (NO_S+1)*8  burst length.
- s_wlast_hs  in  NO_S+1  pulse: WLAST handshake completed on port j.
- wsel  out  (NO_S+1)*MIDX_W  master owning the oldest open burst on port j.
- wsel_valid  out  NO_S+1  FIFO j non-empty.
- wq_err  out  1  sticky flag: pop requested on an empty FIFO.

Behaviour:
- Reset is synchronous and active-high. It clears: all s_awvalid and m_awready, FIFO pointers and counts, wsel_valid, wq_err, all round-robin pointers (to 0), and output registers (0). Reset mid-operation drops in-flight AW beats and FIFO contents with no drain.
- Decode (combinational):
  - Target of master i = lowest j with REGION_START[j] <= addr <= REGION_END[j].
  - No match: target = NO_S.
  - Overlapping regions: the lowest index wins.
- Per port j, a one-deep output register with load enable: load_ok = (!s_awvalid[j] | s_awready[j]) & (!wq_full[j] | s_wlast_hs[j]).
- Arbitration:
  - Candidates for port j are masters with m_awvalid set and target j.
  - The winner is the first candidate at or after rr_ptr[j], wrapping modulo NO_M.
  - When load_ok is set and a candidate exists:
    - m_awready[winner] = 1 in that cycle (combinational).
    - Register loads {winner, id}, offset address and len; s_awvalid[j] = 1 next cycle.
    - rr_ptr[j] becomes (winner+1) mod NO_M.
    - Push winner into FIFO j.
- Latency: m_awvalid to s_awvalid is 1 cycle. Throughput is one AW per port per cycle while s_awready is held high.
- s_awvalid[j] clears on s_awready when nothing new loads in that cycle. The output register is stable while valid and not ready.
- Each master targets one port, so at most one m_awready per master. Different ports grant independently in the same cycle.
- FIFO rules:
  - Push happens on grant.
  - Pop happens on s_wlast_hs[j] when non-empty.
  - Simultaneous push and pop while full is allowed; the count stays at WQ_DEPTH.
  - Push while full with no pop never happens, because load_ok is low.
  - Pop while empty is ignored and sets wq_err (cleared only by reset).
  - wsel = head entry.

Decomposition:
- Package axi_router_pkg holds localparam functions for packed-field slicing and the default region map constants.
- Sub-module axi_rr_arbiter holds the NO_M-wide round-robin arbiter with a pointer and enable. It is instantiated NO_S+1 times.
- The FIFO is written inline per port.

Test Plan:
- M0 addr 0x1004, S1 ready: s_awvalid[1] one cycle later with addr 0x004, id {0,id}, len passed through. FIFO1 holds 0, so wsel[1]=0 and wsel_valid[1]=1.
- M0, M1, M2 all target 0x3000 continuously, S2 ready: grants go M0, M1, M2, M0 on consecutive cycles, and rr_ptr wraps.
- M3 addr 0x200000: routed to the error port (index 6) with raw address 0x200000. No slave 0-5 sees a valid.
- S4 ready held low, 5 requests to 0x107000: the first stays on the S4 output with its fields stable. The second is not granted (m_awready=0) until S4 ready goes high.
- WQ_DEPTH=4, S0 always ready, no wlast: 4 grants, then m_awready stays low. A wlast pulse in cycle 5 allows a grant in the same cycle, with wsel advancing to the second master.
- s_wlast_hs[5] pulsed while FIFO5 is empty: wq_err=1, and it stays set until areset. Asserting areset mid-burst clears every s_awvalid and wsel_valid on the next edge.
